// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// store_monitor : in-order, size-aware checker of data-memory stores
//                 against a programmed table of expected stores.
// Revision      : 1.0
// ============================================================================
module store_monitor #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000,
   parameter int STRICT  = 1,
   localparam int c_IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int c_CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       memwrite,
   input  logic [AW-1:0]    dataadr,
   input  logic [DW-1:0]    writedata,
   input  logic             exp_we,
   input  logic [c_IW-1:0]  exp_idx,
   input  logic [AW-1:0]    exp_addr,
   input  logic [DW-1:0]    exp_data,
   input  logic [1:0]       exp_size,
   input  logic [c_CW-1:0]  exp_count,
   input  logic             start,
   output logic             done,
   output logic             pass,
   output logic [1:0]       fail_code,
   output logic [c_CW-1:0]  match_cnt,
   output logic [AW-1:0]    fail_addr,
   output logic [DW-1:0]    fail_data,
   output logic [31:0]      cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   localparam logic [1:0]  c_FC_NONE = 2'b00;
   localparam logic [1:0]  c_FC_ADDR = 2'b01;
   localparam logic [1:0]  c_FC_DATA = 2'b10;
   localparam logic [1:0]  c_FC_TOUT = 2'b11;
   localparam logic [31:0] c_TOUT_AT = 32'(TIMEOUT - 1);

   state_t             r_state;
   logic               r_done;
   logic               r_pass;
   logic [1:0]         r_fail_code;
   logic [c_CW-1:0]    r_match_cnt;
   logic [c_CW-1:0]    r_count;
   logic [AW-1:0]      r_fail_addr;
   logic [DW-1:0]      r_fail_data;
   logic [31:0]        r_cycles;

   // Expected-store table; deliberately not reset so a bench can rerun it.
   logic [AW-1:0]      r_tab_addr [DEPTH];
   logic [DW-1:0]      r_tab_data [DEPTH];
   logic [1:0]         r_tab_size [DEPTH];

   logic [c_IW-1:0]    w_ptr;
   logic [AW-1:0]      w_exp_addr;
   logic [DW-1:0]      w_exp_data;
   logic [1:0]         w_exp_size;
   logic [DW-1:0]      w_mask;
   logic               w_store;
   logic               w_addr_eq;
   logic               w_size_eq;
   logic               w_data_eq;
   logic               w_timeout;
   logic [c_CW-1:0]    w_next_cnt;
   logic [c_CW-1:0]    w_count_clamp;

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && exp_we && int'(exp_idx) < DEPTH) begin
         r_tab_addr[exp_idx] <= exp_addr;
         r_tab_data[exp_idx] <= exp_data;
         r_tab_size[exp_idx] <= exp_size;
      end
   end

   assign w_ptr      = r_match_cnt[c_IW-1:0];
   assign w_exp_addr = r_tab_addr[w_ptr];
   assign w_exp_data = r_tab_data[w_ptr];
   assign w_exp_size = r_tab_size[w_ptr];

   // Only the lanes the expected size actually writes take part in the compare.
   always_comb begin
      w_mask = '0;
      case (w_exp_size)
         2'b01:   w_mask[7:0]  = '1;
         2'b10:   w_mask[15:0] = '1;
         default: w_mask       = '1;
      endcase
   end

   always_comb begin
      w_count_clamp = exp_count;
      if (int'(exp_count) > DEPTH) begin
         w_count_clamp = c_CW'(DEPTH);
      end
   end

   assign w_store    = (memwrite != 2'b00);
   assign w_addr_eq  = (dataadr == w_exp_addr);
   assign w_size_eq  = (memwrite == w_exp_size);
   assign w_data_eq  = (((writedata ^ w_exp_data) & w_mask) == '0);
   assign w_timeout  = (r_cycles == c_TOUT_AT);
   assign w_next_cnt = r_match_cnt + c_CW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_code <= c_FC_NONE;
         r_match_cnt <= '0;
         r_count     <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         r_cycles    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_count     <= w_count_clamp;
                  r_match_cnt <= '0;
                  r_cycles    <= '0;
                  r_fail_code <= c_FC_NONE;
                  r_fail_addr <= '0;
                  r_fail_data <= '0;
                  if (w_count_clamp == '0) begin
                     r_state <= S_PASS;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (r_cycles != '1) begin
                  r_cycles <= r_cycles + 32'd1;
               end
               // A store verdict in this cycle takes priority over the timeout.
               if (w_store && w_addr_eq) begin
                  if (w_size_eq && w_data_eq) begin
                     r_match_cnt <= w_next_cnt;
                     if (w_next_cnt == r_count) begin
                        r_state <= S_PASS;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                     end else if (w_timeout) begin
                        r_state     <= S_FAIL;
                        r_done      <= 1'b1;
                        r_fail_code <= c_FC_TOUT;
                     end
                  end else begin
                     r_state     <= S_FAIL;
                     r_done      <= 1'b1;
                     r_fail_code <= c_FC_DATA;
                     r_fail_addr <= dataadr;
                     r_fail_data <= writedata;
                  end
               end else if (w_store && STRICT != 0) begin
                  r_state     <= S_FAIL;
                  r_done      <= 1'b1;
                  r_fail_code <= c_FC_ADDR;
                  r_fail_addr <= dataadr;
                  r_fail_data <= writedata;
               end else if (w_timeout) begin
                  r_state     <= S_FAIL;
                  r_done      <= 1'b1;
                  r_fail_code <= c_FC_TOUT;
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   assign done      = r_done;
   assign pass      = r_pass;
   assign fail_code = r_fail_code;
   assign match_cnt = r_match_cnt;
   assign fail_addr = r_fail_addr;
   assign fail_data = r_fail_data;
   assign cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
// tb_store_monitor : directed checks of store_monitor (strict and lenient).
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_store_monitor;

   localparam int c_AW = 32;
   localparam int c_DW = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       memwrite;
   logic [c_AW-1:0]  dataadr;
   logic [c_DW-1:0]  writedata;
   logic             exp_we;
   logic [1:0]       exp_idx;
   logic [c_AW-1:0]  exp_addr;
   logic [c_DW-1:0]  exp_data;
   logic [1:0]       exp_size;
   logic [2:0]       exp_count;
   logic             start;

   logic             done, pass;
   logic [1:0]       fail_code;
   logic [2:0]       match_cnt;
   logic [c_AW-1:0]  fail_addr;
   logic [c_DW-1:0]  fail_data;
   logic [31:0]      cycles;

   logic             ns_done, ns_pass;
   logic [1:0]       ns_fail_code;
   logic [2:0]       ns_match_cnt;
   logic [c_AW-1:0]  ns_fail_addr;
   logic [c_DW-1:0]  ns_fail_data;
   logic [31:0]      ns_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   store_monitor #(.AW(c_AW), .DW(c_DW), .DEPTH(4), .TIMEOUT(20), .STRICT(1)) u_dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
      .exp_addr(exp_addr), .exp_data(exp_data), .exp_size(exp_size),
      .exp_count(exp_count), .start(start), .done(done), .pass(pass),
      .fail_code(fail_code), .match_cnt(match_cnt), .fail_addr(fail_addr),
      .fail_data(fail_data), .cycles(cycles)
   );

   store_monitor #(.AW(c_AW), .DW(c_DW), .DEPTH(4), .TIMEOUT(20), .STRICT(0)) u_dut_ns (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
      .exp_addr(exp_addr), .exp_data(exp_data), .exp_size(exp_size),
      .exp_count(exp_count), .start(start), .done(ns_done), .pass(ns_pass),
      .fail_code(ns_fail_code), .match_cnt(ns_match_cnt), .fail_addr(ns_fail_addr),
      .fail_data(ns_fail_data), .cycles(ns_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wr_entry(input logic [1:0] idx, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz);
      exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d; exp_size = sz;
      tick();
      exp_we = 1'b0;
   endtask

   task automatic start_run(input logic [2:0] cnt);
      exp_count = cnt; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      memwrite = sz; dataadr = a; writedata = d;
      tick();
      memwrite = 2'b00;
   endtask

   initial begin
      reset = 1'b0; memwrite = 2'b00; dataadr = '0; writedata = '0;
      exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
      exp_size = 2'b11; exp_count = '0; start = 1'b0;

      // Reset state
      do_reset();
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_code", fail_code, 0);
      check("rst_cnt", match_cnt, 0);
      check("rst_faddr", fail_addr, 0);
      check("rst_fdata", fail_data, 0);
      check("rst_cycles", cycles, 0);

      // Single correct word store
      wr_entry(2'd0, 32'd84, 32'hFFFF7F02, 2'b11);
      start_run(3'd1);
      check("t1_idle_done", done, 0);
      store(2'b11, 32'd84, 32'hFFFF7F02);
      check("t1_done", done, 1);
      check("t1_pass", pass, 1);
      check("t1_cnt", match_cnt, 1);
      check("t1_code", fail_code, 0);
      check("t1_cycles", cycles, 1);

      // Wrong data at the expected address
      do_reset();
      start_run(3'd1);
      store(2'b11, 32'd84, 32'hFFFF7F03);
      check("t2_done", done, 1);
      check("t2_pass", pass, 0);
      check("t2_code", fail_code, 2'b10);
      check("t2_faddr", fail_addr, 84);
      check("t2_fdata", fail_data, 32'hFFFF7F03);
      check("t2_cnt", match_cnt, 0);

      // Stray store before the expected one: strict fails, lenient ignores
      do_reset();
      start_run(3'd1);
      store(2'b11, 32'd80, 32'hFFFF7F02);
      check("t3_code", fail_code, 2'b01);
      check("t3_faddr", fail_addr, 80);
      check("t3_ns_done", ns_done, 0);
      store(2'b11, 32'd84, 32'hFFFF7F02);
      check("t3_sticky_code", fail_code, 2'b01);
      check("t3_sticky_faddr", fail_addr, 80);
      check("t3_ns_pass", ns_pass, 1);
      check("t3_ns_cnt", ns_match_cnt, 1);
      check("t3_ns_code", ns_fail_code, 0);
      check("t3_ns_faddr", ns_fail_addr, 0);
      check("t3_ns_fdata", ns_fail_data, 0);
      check("t3_ns_cycles", ns_cycles, 2);

      // Mixed sizes back-to-back with garbage in unused lanes
      do_reset();
      wr_entry(2'd0, 32'h10, 32'h000000AB, 2'b01);
      wr_entry(2'd1, 32'h14, 32'h00001234, 2'b10);
      wr_entry(2'd2, 32'h18, 32'hDEADBEEF, 2'b11);
      start_run(3'd3);
      memwrite = 2'b01; dataadr = 32'h10; writedata = 32'h5555_66AB;
      tick();
      check("t4_cnt1", match_cnt, 1);
      memwrite = 2'b10; dataadr = 32'h14; writedata = 32'h9999_1234;
      tick();
      check("t4_cnt2", match_cnt, 2);
      check("t4_done2", done, 0);
      memwrite = 2'b11; dataadr = 32'h18; writedata = 32'hDEADBEEF;
      tick();
      memwrite = 2'b00;
      check("t4_cnt3", match_cnt, 3);
      check("t4_pass", pass, 1);

      // Size mismatch on the second entry
      do_reset();
      start_run(3'd3);
      store(2'b01, 32'h10, 32'h000000AB);
      store(2'b01, 32'h14, 32'h00000034);
      check("t5_code", fail_code, 2'b10);
      check("t5_cnt", match_cnt, 1);
      check("t5_fdata", fail_data, 32'h34);

      // Count above DEPTH clamps to DEPTH
      do_reset();
      wr_entry(2'd3, 32'h1C, 32'h00000000, 2'b11);
      start_run(3'd7);
      store(2'b01, 32'h10, 32'hFFFFFFAB);
      store(2'b10, 32'h14, 32'h00001234);
      store(2'b11, 32'h18, 32'hDEADBEEF);
      check("t6_not_yet", done, 0);
      store(2'b11, 32'h1C, 32'h00000000);
      check("t6_pass", pass, 1);
      check("t6_cnt", match_cnt, 4);

      // Timeout with no stores, then reset retains the table
      do_reset();
      start_run(3'd1);
      for (int i = 0; i < 19; i++) tick();
      check("t7_pre_done", done, 0);
      check("t7_pre_cycles", cycles, 19);
      tick();
      check("t7_done", done, 1);
      check("t7_code", fail_code, 2'b11);
      check("t7_cycles", cycles, 20);
      check("t7_faddr", fail_addr, 0);
      check("t7_ns_code", ns_fail_code, 2'b11);
      do_reset();
      check("t7_rst_done", done, 0);
      check("t7_rst_code", fail_code, 0);
      check("t7_rst_cycles", cycles, 0);
      wr_entry(2'd0, 32'd84, 32'hFFFF7F02, 2'b11);
      start_run(3'd1);
      store(2'b11, 32'd84, 32'hFFFF7F02);
      check("t7_rerun_pass", pass, 1);

      // Count of zero passes on the next edge
      do_reset();
      start_run(3'd0);
      check("t8_done", done, 1);
      check("t8_pass", pass, 1);
      check("t8_cnt", match_cnt, 0);

      // Final match on the timeout edge: the match wins
      do_reset();
      start_run(3'd1);
      for (int i = 0; i < 19; i++) tick();
      store(2'b11, 32'd84, 32'hFFFF7F02);
      check("t9_pass", pass, 1);
      check("t9_code", fail_code, 0);
      check("t9_cycles", cycles, 20);

      // Table writes are ignored outside IDLE
      do_reset();
      start_run(3'd1);
      wr_entry(2'd0, 32'd200, 32'h0, 2'b11);
      store(2'b11, 32'd84, 32'hFFFF7F02);
      check("t10_pass", pass, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/store_monitor.md
# store_monitor

Parametrised, synthesizable store-sequence checker for the MIPS single-cycle testbench environment. It sits beside the `top` processor instance and watches the data-memory write port (`memwrite`, `dataadr`, `writedata`). It compares stores against a programmed table of up to DEPTH expected stores, matched in order, with byte, halfword or word size awareness. Outcomes are a pass/fail verdict with a failure code, captured failing transaction and a cycle-bounded timeout, which replaces single-address ad-hoc checks in benches.

## Interface
- AW, 32, address width of `dataadr`/`exp_addr`
- DW, 32, data width of `writedata`/`exp_data`
- DEPTH, 4, expected-store table entries (≥1)
- TIMEOUT, 1000, RUN cycles allowed before timeout failure (≥1)
- STRICT, 1, 1: store to a non-expected address fails; 0: such stores are ignored

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- memwrite  in  2  store size: 00 none, 01 byte, 10 halfword, 11 word
- dataadr  in  AW  store address
- writedata  in  DW  store data
- exp_we  in  1  table write strobe (honoured in IDLE only)
- exp_idx  in  $clog2(DEPTH)  table entry index
- exp_addr  in  AW  expected address
- exp_data  in  DW  expected data
- exp_size  in  2  expected size, same encoding as `memwrite` (00 is illegal)
- exp_count  in  $clog2(DEPTH+1)  number of valid entries, sampled on `start`
- start  in  1  arm pulse, IDLE→RUN
- done  out  1  verdict reached (PASS or FAIL state)
- pass  out  1  PASS state
- fail_code  out  2  00 none, 01 address, 10 data/size, 11 timeout
- match_cnt  out  $clog2(DEPTH+1)  entries matched so far
- fail_addr  out  AW  `dataadr` of offending store (0 on timeout)
- fail_data  out  DW  `writedata` of offending store (0 on timeout)
- cycles  out  32  RUN cycles elapsed, saturating

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE, and all outputs are 0. Table contents are not cleared by reset.
- IDLE: `exp_we` writes entry `exp_idx`. Indices ≥ DEPTH are ignored. `start` latches `exp_count` (clamped to DEPTH), clears `match_cnt`, `cycles` and `fail_*`, then enters RUN. If `start` and `exp_we` occur together, the table write takes effect and `start` sees the pre-write table.
- `start` with `exp_count`=0 goes IDLE→PASS directly.
- RUN: a store (`memwrite`≠00) is compared against entry `ptr`=`match_cnt`.
  - Address equal, size equal and masked data equal → match. Mask: byte [7:0], halfword [15:0], word [DW-1:0].
  - On match, `match_cnt`+1. If the new value equals the latched count → PASS.
  - Address equal, but size or masked data differ → FAIL, code 10.
  - Address differs: with STRICT=1 → FAIL, code 01. With STRICT=0 → ignored.
- `cycles` increments every RUN cycle. When `cycles` reaches TIMEOUT-1 with no verdict in that cycle → FAIL, code 11.
- Store verdict and timeout in the same cycle: the store verdict wins.
- PASS/FAIL are sticky. Only `reset` returns to IDLE. `start` and `exp_we` are ignored outside IDLE.
- `reset` asserted mid-RUN aborts the check with no verdict; outputs clear on the next edge.

## Timing
- All outputs are registered. A store sampled at edge N is reflected in `match_cnt`/`done`/`pass`/`fail_*` after edge N.
- `start` at edge N puts the block in RUN from edge N. The first store that can be checked is the one sampled at edge N+1.
- One store is evaluated per cycle, with no back-pressure. Consecutive-cycle stores are all checked.
- Timeout: with no stores, `done` rises after exactly TIMEOUT rising edges in RUN. `cycles` reads TIMEOUT at that point.
- `cycles` saturates at 2^32-1.

## Test plan
- Entry0={84, 32'hFFFF7F02, word}, count=1, start, then a word store at 84 with FFFF7F02 → next cycle done=1, pass=1, match_cnt=1, fail_code=00.
- Same table, word store at 84 with 32'hFFFF7F03 → done=1, pass=0, fail_code=10, fail_addr=84, fail_data=FFFF7F03.
- STRICT=1, store at 80 before the expected store → fail_code=01, fail_addr=80. With STRICT=0 the same stimulus followed by the correct store → pass=1.
- DEPTH=4, entries {0x10 byte 0xAB, 0x14 half 0x1234, 0x18 word 0xDEADBEEF}, count=3, stores issued back-to-back with upper bits of byte/half data set to garbage → match_cnt 1,2,3 on consecutive cycles, then pass=1.
- TIMEOUT=20, count=1, no stores → done=1 with fail_code=11 exactly 20 cycles after start. Then `reset` → all outputs 0 and state IDLE; the table is retained and a rerun passes.
- `start` with count=0 → pass=1 the next cycle. A store on the same edge as the final match and timeout → pass wins.
